hilo_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers. The execute stage issues MULT, MULTU, DIV, DIVU, MTHI and MTLO into this unit. The unit returns the current `hi`/`lo` values that the execute stage consumes for MFHI/MFLO. While an operation is in flight, `busy` tells the hazard logic to stall any instruction that reads or writes HI/LO.

---
 rtl/hilo_muldiv_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with 33-cycle iterative MULT/MULTU/DIV/DIVU and 1-cycle MTHI/MTLO.
// Define HILO_FAST_MULT_EN to replace the shift-add multiply with a registered single-cycle product.
module hilo_muldiv_unit #(
   parameter int unsigned ITER_BITS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_t;

   generate
      if (ITER_BITS != 1) begin : g_iter_check
         $error("hilo_muldiv_unit: only ITER_BITS=1 is supported");
      end
   endgenerate

   state_t      r_state;
   state_t      w_state_n;

   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic [5:0]  r_cnt;
   logic [63:0] r_prod;
   logic [63:0] r_mcand;
   logic [31:0] r_mplr;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_div;
   logic        r_neg;
   logic        r_rneg;
   logic        r_is_div;

   logic        w_go;
   logic        w_signed;
   logic        w_sa;
   logic        w_sb;
   logic        w_last;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_shift;
   logic        w_fits;
   logic [31:0] w_diff;
   logic [63:0] w_prod_fix;

`ifdef HILO_FAST_MULT_EN
   logic [63:0] w_fast_a;
   logic [63:0] w_fast_b;
   logic [63:0] w_fast_prod;

   // Sign/zero-extend to 64 bits so one unsigned multiply serves MULT and MULTU.
   always_comb begin
      w_fast_a    = {{32{w_sa}}, a};
      w_fast_b    = {{32{w_sb}}, b};
      w_fast_prod = w_fast_a * w_fast_b;
   end
`endif

   always_comb begin
      w_signed   = ~op[0];
      w_sa       = w_signed & a[31];
      w_sb       = w_signed & b[31];
      w_abs_a    = w_sa ? (~a + 32'd1) : a;
      w_abs_b    = w_sb ? (~b + 32'd1) : b;
      w_shift    = {r_rem, r_quo[31]};
      w_fits     = (w_shift >= {1'b0, r_div});
      w_diff     = w_shift[31:0] - r_div;
      w_prod_fix = r_neg ? (~r_prod + 64'd1) : r_prod;
      w_last     = (r_cnt == 6'd31);
   end

   always_comb begin
      w_state_n = r_state;
      w_go      = 1'b0;
      case (r_state)
         IDLE: begin
            w_go = start & ~cancel;
            if (w_go) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                     w_state_n = FIX;
`else
                     w_state_n = MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: w_state_n = DIV;
                  default:         w_state_n = IDLE;
               endcase
            end
         end
         MUL, DIV: begin
            if (cancel) begin
               w_state_n = IDLE;
            end else if (w_last) begin
               w_state_n = FIX;
            end
         end
         FIX:     w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_neg    <= 1'b0;
         r_rneg   <= 1'b0;
         r_is_div <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  case (op)
                     OP_MTHI: r_hi <= a;
                     OP_MTLO: r_lo <= a;
                     OP_MULT, OP_MULTU: begin
                        r_is_div <= 1'b0;
                        r_cnt    <= '0;
                        r_rneg   <= w_sa;
`ifdef HILO_FAST_MULT_EN
                        r_prod   <= w_fast_prod;
                        r_neg    <= 1'b0;
`else
                        r_prod   <= '0;
                        r_mcand  <= {32'd0, w_abs_a};
                        r_mplr   <= w_abs_b;
                        r_neg    <= w_sa ^ w_sb;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        r_is_div <= 1'b1;
                        r_cnt    <= '0;
                        r_rneg   <= w_sa;
                        // Zero divisor keeps the quotient positive so LO reads all-ones.
                        r_neg    <= (w_sa ^ w_sb) & (b != '0);
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_div    <= w_abs_b;
                     end
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (r_mplr[0]) begin
                  r_prod <= r_prod + r_mcand;
               end
               r_mcand <= r_mcand << 1;
               r_mplr  <= r_mplr >> 1;
               r_cnt   <= r_cnt + 6'd1;
            end
            DIV: begin
               if (w_fits) begin
                  r_rem <= w_diff;
                  r_quo <= {r_quo[30:0], 1'b1};
               end else begin
                  r_rem <= w_shift[31:0];
                  r_quo <= {r_quo[30:0], 1'b0};
               end
               r_cnt <= r_cnt + 6'd1;
            end
            FIX: begin
               if (!cancel) begin
                  r_done <= 1'b1;
                  if (r_is_div) begin
                     r_lo <= r_neg  ? (~r_quo + 32'd1) : r_quo;
                     r_hi <= r_rneg ? (~r_rem + 32'd1) : r_rem;
                  end else begin
                     r_hi <= w_prod_fix[63:32];
                     r_lo <= w_prod_fix[31:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit: mul/div results, latency, cancel and hold behaviour.
module tb_hilo_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef HILO_FAST_MULT_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   hilo_muldiv_unit #(.ITER_BITS(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Issue one op, then wait (bounded) for done; lat = edges after acceptance, -1 on timeout.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic busy0);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy0 = busy;
      lat   = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic load(input logic [2:0] o, input logic [31:0] x);
      op = o; a = x; b = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
      n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
      reset = 1'b0;
   endtask

   task automatic test_mult_signed;
      int lat; logic b0;
      run_op(3'd0, 32'hFFFF_FFFF, 32'd7, lat, b0);
      n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL mult_busy_e0: got %b expected 1", b0); end
      n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mult_latency: got %0d expected %0d", lat, MUL_LAT); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      n_checks++; if (lo !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff9", lo); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_after: got %b expected 0", busy); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat, b0);
      n_checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin n_fail++; $display("FAIL mult_minmin: got %h_%h expected 40000000_00000000", hi, lo); end
   endtask

   task automatic test_multu;
      int lat; logic b0;
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b0);
      n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL multu_latency: got %0d expected %0d", lat, MUL_LAT); end
      n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
      n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
   endtask

   task automatic test_div;
      int lat; logic b0;
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, b0);
      n_checks++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); end
      n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
      n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, lat, b0);
      n_checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin n_fail++; $display("FAIL div_negb: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", hi, lo); end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0);
      n_checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo); end
   endtask

   task automatic test_div_zero;
      int lat; logic b0;
      run_op(3'd3, 32'd100, 32'd0, lat, b0);
      n_checks++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL divu0_latency: got %0d expected %0d", lat, DIV_LAT); end
      n_checks++; if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_result: got hi=%h lo=%h expected hi=00000064 lo=ffffffff", hi, lo); end
      run_op(3'd2, 32'hFFFF_FFF9, 32'd0, lat, b0);
      n_checks++; if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_signed: got hi=%h lo=%h expected hi=fffffff9 lo=ffffffff", hi, lo); end
   endtask

   task automatic test_mt;
      load(3'd5, 32'h0000_0BAD);
      n_checks++; if (lo !== 32'h0000_0BAD) begin n_fail++; $display("FAIL mtlo_value: got %h expected 00000bad", lo); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtlo_flags: got busy=%b done=%b expected 0 0", busy, done); end
      load(3'd4, 32'h0000_1234);
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_value: got %h expected 00001234", hi); end
   endtask

   task automatic test_cancel;
      logic seen_done;
      op = 3'd3; a = 32'd10; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", busy); end
      n_checks++; if (hi !== 32'h0000_1234 || lo !== 32'h0000_0BAD) begin n_fail++; $display("FAIL cancel_hilo: got hi=%h lo=%h expected hi=00001234 lo=00000bad", hi, lo); end
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b expected 0", seen_done); end
   endtask

   task automatic test_cancel_idle;
      cancel = 1'b1; start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL cancel_idle_mthi: got %h expected 00001234", hi); end
      op = 3'd3; a = 32'd10; b = 32'd3;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_divu: got busy=%b expected 0", busy); end
      cancel = 1'b0; start = 1'b0;
   endtask

   task automatic test_cancel_fix;
      op = 3'd3; a = 32'd10; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      n_checks++; if (hi !== 32'h0000_1234 || lo !== 32'h0000_0BAD) begin n_fail++; $display("FAIL cancel_fix_hilo: got hi=%h lo=%h expected hi=00001234 lo=00000bad", hi, lo); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL cancel_fix_flags: got busy=%b done=%b expected 0 0", busy, done); end
   endtask

   task automatic test_noop;
      op = 3'd6; a = 32'hAAAA_AAAA; b = 32'h5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (busy !== 1'b0 || hi !== 32'h0000_1234 || lo !== 32'h0000_0BAD) begin n_fail++; $display("FAIL noop: got busy=%b hi=%h lo=%h expected 0 00001234 00000bad", busy, hi, lo); end
   endtask

   task automatic test_back_to_back;
      int edges; logic lo_kept;
      load(3'd5, 32'h0000_5555);
      op = 3'd3; a = 32'd10; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      op = 3'd5; a = 32'h0000_CAFE; b = '0;
      edges   = -1;
      lo_kept = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (busy === 1'b0) begin
            edges = i;
            break;
         end
         if (lo !== 32'h0000_5555) lo_kept = 1'b0;
      end
      n_checks++; if (lo_kept !== 1'b1) begin n_fail++; $display("FAIL b2b_held_ignored: got %b expected 1", lo_kept); end
      n_checks++; if (edges !== DIV_LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", edges, DIV_LAT); end
      n_checks++; if (done !== 1'b1 || lo !== 32'd3 || hi !== 32'd1) begin n_fail++; $display("FAIL b2b_divu: got done=%b hi=%h lo=%h expected 1 00000001 00000003", done, hi, lo); end
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (lo !== 32'h0000_CAFE || hi !== 32'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_mtlo: got busy=%b hi=%h lo=%h expected 0 00000001 0000cafe", busy, hi, lo); end
   endtask

   task automatic test_reset_mid;
      op = 3'd2; a = 32'd50; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo); end
   endtask

   initial begin
      test_reset();
      test_mult_signed();
      test_multu();
      test_div();
      test_div_zero();
      test_mt();
      test_cancel();
      test_cancel_idle();
      test_cancel_fix();
      test_noop();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
